// File: rtl/mem_sp_sky130_rmw.sv
// Tiled single-port SRAM subsystem on sky130 32x128 macros with valid/ready request and registered read response.
// Define MEM_SKY130_RMW_EN to build bit-masked writes via a one-cycle read-modify-write state.

// Behavioural stand-in for the hard macro: inputs captured on posedge, array accessed on negedge.
module sky130_sram_0kbytes_1rw_32x128_32 (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [7:0]  addr0,
  input  logic [32:0] din0,
  output logic [32:0] dout0
);
  logic [32:0] mem [256];
  logic        csb_q;
  logic        web_q;
  logic [3:0]  wmask_q;
  logic [7:0]  addr_q;
  logic [32:0] din_q;

  always_ff @(posedge clk0) begin
    csb_q   <= csb0;
    web_q   <= web0;
    wmask_q <= wmask0;
    addr_q  <= addr0;
    din_q   <= din0;
  end

  always_ff @(negedge clk0) begin
    if (!csb_q) begin
      if (!web_q) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask_q[i]) mem[addr_q][i*8 +: 8] <= din_q[i*8 +: 8];
        end
        if (wmask_q[3]) mem[addr_q][32] <= din_q[32];
      end else begin
        dout0 <= mem[addr_q];
      end
    end
  end
endmodule

module mem_sp_sky130_rmw #(
  parameter int unsigned DATA_BIT    = 64,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned MACRO_WIDTH = 32,
  parameter int unsigned MACRO_DEPTH = 128,
  parameter int unsigned ADDR_BIT    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_BIT-1:0] req_addr,
  input  logic [DATA_BIT-1:0] req_bwe,
  input  logic [DATA_BIT-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [DATA_BIT-1:0] rsp_rdata,
  output logic                addr_err
);
  localparam int unsigned NUM_BANKS = (DATA_BIT + MACRO_WIDTH - 1) / MACRO_WIDTH;
  localparam int unsigned NUM_TILES = (DEPTH + MACRO_DEPTH - 1) / MACRO_DEPTH;
  localparam int unsigned PAD_BIT   = NUM_BANKS * MACRO_WIDTH;
  localparam int unsigned LOCAL_BIT = $clog2(MACRO_DEPTH);
  localparam int unsigned TILE_BIT  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  logic [MACRO_WIDTH:0] dout_w [NUM_TILES][NUM_BANKS];
  logic [PAD_BIT-1:0]   wdata_pad_c;
  logic [PAD_BIT-1:0]   bwe_pad_c;
  logic [PAD_BIT-1:0]   rd_word_c;
  logic [PAD_BIT-1:0]   din_c;
  logic [NUM_BANKS-1:0] any_en_c;
  logic [NUM_BANKS-1:0] bank_cs_c;
  logic                 in_range_c;
  logic                 accept_c;
  logic                 web_c;
  logic [TILE_BIT-1:0]  tile_c;
  logic [TILE_BIT-1:0]  sel_tile_c;
  logic [TILE_BIT-1:0]  dout_tile_q;
  logic [LOCAL_BIT-1:0] local_c;
  logic [LOCAL_BIT-1:0] sel_local_c;
  logic                 rd_pend_q;
  logic                 rd_err_q;

  assign wdata_pad_c = PAD_BIT'(req_wdata);
  assign bwe_pad_c   = PAD_BIT'(req_bwe);
  assign in_range_c  = 32'(req_addr) < DEPTH;
  assign tile_c      = TILE_BIT'(req_addr >> LOCAL_BIT);
  assign local_c     = LOCAL_BIT'(req_addr);
  assign accept_c    = req_valid & req_ready;

  always_comb begin
    any_en_c = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      any_en_c[b] = |bwe_pad_c[b*MACRO_WIDTH +: MACRO_WIDTH];
    end
  end

`ifdef MEM_SKY130_RMW_EN
  typedef enum logic {S_IDLE, S_RMW} state_t;

  // Padding bits count as enabled so a fully-masked top bank is not mistaken for a mixed one.
  localparam logic [PAD_BIT-1:0] PAD_ONES = ~PAD_BIT'({DATA_BIT{1'b1}});

  state_t               state_q;
  state_t               state_d;
  logic [PAD_BIT-1:0]   bwe_full_c;
  logic [PAD_BIT-1:0]   merged_c;
  logic [NUM_BANKS-1:0] mixed_c;
  logic [NUM_BANKS-1:0] l_en_q;
  logic [TILE_BIT-1:0]  l_tile_q;
  logic [LOCAL_BIT-1:0] l_local_q;
  logic [PAD_BIT-1:0]   l_wdata_q;
  logic [PAD_BIT-1:0]   l_bwe_q;

  assign req_ready  = (state_q == S_IDLE);
  assign bwe_full_c = bwe_pad_c | PAD_ONES;
  assign merged_c   = (rd_word_c & ~l_bwe_q) | (l_wdata_q & l_bwe_q);

  always_comb begin
    mixed_c = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      mixed_c[b] = any_en_c[b] & ~(&bwe_full_c[b*MACRO_WIDTH +: MACRO_WIDTH]);
    end
  end

  // State register plus the write request held across the RMW cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      l_en_q    <= '0;
      l_tile_q  <= '0;
      l_local_q <= '0;
      l_wdata_q <= '0;
      l_bwe_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c && req_wen) begin
        l_en_q    <= any_en_c;
        l_tile_q  <= tile_c;
        l_local_q <= local_c;
        l_wdata_q <= wdata_pad_c;
        l_bwe_q   <= bwe_full_c;
      end
    end
  end
`else
  assign req_ready = 1'b1;
`endif

  // Macro command: next state and per-bank select/write controls.
  always_comb begin
    sel_tile_c  = tile_c;
    sel_local_c = local_c;
    web_c       = 1'b1;
    bank_cs_c   = '0;
    din_c       = wdata_pad_c;
`ifdef MEM_SKY130_RMW_EN
    state_d = state_q;
    if (state_q == S_RMW) begin
      sel_tile_c  = l_tile_q;
      sel_local_c = l_local_q;
      web_c       = 1'b0;
      bank_cs_c   = l_en_q;
      din_c       = merged_c;
      state_d     = S_IDLE;
    end
`endif
    if (accept_c && in_range_c) begin
      if (!req_wen) begin
        bank_cs_c = '1;
      end else begin
        bank_cs_c = any_en_c;
        web_c     = 1'b0;
`ifdef MEM_SKY130_RMW_EN
        if (|mixed_c) begin
          bank_cs_c = mixed_c;
          web_c     = 1'b1;
          state_d   = S_RMW;
        end
`endif
      end
    end
  end

  // Word assembled from the tile addressed by the most recent accepted access.
  always_comb begin
    rd_word_c = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      if (TILE_BIT'(t) == dout_tile_q) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          rd_word_c[b*MACRO_WIDTH +: MACRO_WIDTH] = MACRO_WIDTH'(dout_w[t][b]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      dout_tile_q <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      addr_err    <= 1'b0;
    end else begin
      rd_pend_q <= accept_c & ~req_wen;
      rd_err_q  <= ~in_range_c;
      addr_err  <= accept_c & ~in_range_c;
      if (accept_c && in_range_c) dout_tile_q <= tile_c;
      rsp_valid <= rd_pend_q;
      if (rd_pend_q) rsp_rdata <= rd_err_q ? '0 : DATA_BIT'(rd_word_c);
    end
  end

  for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sky130_sram_0kbytes_1rw_32x128_32 u_macro (
        .clk0   (clk),
        .csb0   (~(bank_cs_c[b] & (sel_tile_c == TILE_BIT'(t)))),
        .web0   (web_c),
        .wmask0 (4'hF),
        .addr0  (8'(sel_local_c)),
        .din0   (33'(din_c[b*MACRO_WIDTH +: MACRO_WIDTH])),
        .dout0  (dout_w[t][b])
      );
    end
  end
endmodule

// File: tb/tb_mem_sp_sky130_rmw.sv
// Bench for mem_sp_sky130_rmw: 64x512 instance (vector table + scoreboard) and 40x300 instance (range and odd width).
module tb_mem_sp_sky130_rmw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_wen, a_rsp_valid, a_err;
  logic [8:0]  a_addr;
  logic [63:0] a_bwe, a_wdata, a_rdata;
  logic        b_valid, b_ready, b_wen, b_rsp_valid, b_err;
  logic [8:0]  b_addr;
  logic [39:0] b_bwe, b_wdata, b_rdata;

  mem_sp_sky130_rmw #(.DATA_BIT(64), .DEPTH(512)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_wen(a_wen),
    .req_addr(a_addr), .req_bwe(a_bwe), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .addr_err(a_err));

  mem_sp_sky130_rmw #(.DATA_BIT(40), .DEPTH(300)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_wen(b_wen),
    .req_addr(b_addr), .req_bwe(b_bwe), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .addr_err(b_err));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        wen;
    logic [8:0]  addr;
    logic [63:0] bwe;
    logic [63:0] wdata;
    logic [63:0] expd;
  } vec_t;
  vec_t vecs[13];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [39:0] B_ONES = 40'hFF_FFFF_FFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expd);
    checks++;
    if (act !== expd) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expd);
    end
  endtask

  // Response scoreboard for the 64-bit instance: data and arrival cycle.
  always @(negedge clk) begin
    if (a_rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_rsp_unexpected: got rsp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("a_rsp_data", a_rdata, e.data);
        check("a_rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic a_send(input logic wen, input logic [8:0] addr, input logic [63:0] bwe,
                        input logic [63:0] wdata, input logic [63:0] expd);
    int n = 0;
    a_valid = 1'b1;
    a_wen   = wen;
    a_addr  = addr;
    a_bwe   = bwe;
    a_wdata = wdata;
    while (!a_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      checks++;
      failures++;
      $display("FAIL a_ready_timeout: got req_ready=0 for %0d cycles expected 1", n);
    end else if (!wen) begin
      sb.push_back('{data: expd, due: cyc + 2});
    end
    @(negedge clk);
  endtask

  task automatic a_idle(input int cycles);
    a_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic b_op(input logic wen, input logic [8:0] addr, input logic [39:0] wdata);
    b_valid = 1'b1;
    b_wen   = wen;
    b_addr  = addr;
    b_bwe   = B_ONES;
    b_wdata = wdata;
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 9'd5,   ONES, 64'hDEADBEEF_01234567, 64'h0};
    vecs[1]  = '{1'b0, 9'd5,   ONES, 64'h0, 64'hDEADBEEF_01234567};
    vecs[2]  = '{1'b1, 9'd127, ONES, 64'h0000007F_A5A50127, 64'h0};
    vecs[3]  = '{1'b1, 9'd128, ONES, 64'h80800128_5A5A0000, 64'h0};
    vecs[4]  = '{1'b1, 9'd511, ONES, 64'hFFFF01FF_12345678, 64'h0};
    vecs[5]  = '{1'b0, 9'd127, ONES, 64'h0, 64'h0000007F_A5A50127};
    vecs[6]  = '{1'b0, 9'd128, ONES, 64'h0, 64'h80800128_5A5A0000};
    vecs[7]  = '{1'b0, 9'd511, ONES, 64'h0, 64'hFFFF01FF_12345678};
    vecs[8]  = '{1'b1, 9'd0,   ONES, 64'h11111111_22222222, 64'h0};
    vecs[9]  = '{1'b1, 9'd0,   64'hFFFFFFFF_00000000, 64'hCAFEF00D_99999999, 64'h0};
    vecs[10] = '{1'b1, 9'd0,   64'h0, ONES, 64'h0};
    vecs[11] = '{1'b0, 9'd0,   ONES, 64'h0, 64'hCAFEF00D_22222222};
    vecs[12] = '{1'b0, 9'd128, ONES, 64'h0, 64'h80800128_5A5A0000};

    a_valid = 1'b0; a_wen = 1'b0; a_addr = '0; a_bwe = '0; a_wdata = '0;
    b_valid = 1'b0; b_wen = 1'b0; b_addr = '0; b_bwe = '0; b_wdata = '0;

    repeat (3) @(negedge clk);
    check("reset_a_ready", 64'(a_ready), 64'd1);
    check("reset_a_rsp_valid", 64'(a_rsp_valid), 64'd0);
    check("reset_a_rdata", a_rdata, 64'd0);
    check("reset_a_err", 64'(a_err), 64'd0);
    check("reset_b_ready", 64'(b_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back vectors: basic access, tile boundaries, bank skipping.
    for (int i = 0; i < 13; i++) begin
      a_send(vecs[i].wen, vecs[i].addr, vecs[i].bwe, vecs[i].wdata, vecs[i].expd);
    end
    a_idle(4);

    // Mixed-mask write on a word of all ones.
    a_send(1'b1, 9'd9, ONES, ONES, 64'h0);
    a_send(1'b1, 9'd9, 64'h00000000_0000FF00, 64'h0, 64'h0);
`ifdef MEM_SKY130_RMW_EN
    check("a_rmw_ready_low", 64'(a_ready), 64'd0);
    a_send(1'b0, 9'd9, ONES, 64'h0, 64'hFFFFFFFF_FFFF00FF);
`else
    check("a_direct_ready", 64'(a_ready), 64'd1);
    a_send(1'b0, 9'd9, ONES, 64'h0, 64'hFFFFFFFF_00000000);
`endif
    a_idle(4);

    // Reset asserted in the cycle after a mixed-mask write is accepted.
    a_send(1'b1, 9'd20, ONES, 64'h12345678_9ABCDEF0, 64'h0);
    a_send(1'b1, 9'd30, ONES, 64'hAAAA5555_AAAA5555, 64'h0);
    a_send(1'b1, 9'd20, 64'h00FF0000_00000000, 64'h0, 64'h0);
    a_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 64'(a_ready), 64'd1);
    check("rst_mid_rsp_valid", 64'(a_rsp_valid), 64'd0);
    check("rst_mid_rdata", a_rdata, 64'd0);
    check("rst_mid_err", 64'(a_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_send(1'b0, 9'd30, ONES, 64'h0, 64'hAAAA5555_AAAA5555);
    a_idle(4);

    // 40-bit, 300-deep instance: range errors, aliasing, odd width.
    b_op(1'b1, 9'd144, 40'h12_3456789A);
    check("b_err_inrange", 64'(b_err), 64'd0);
    b_op(1'b1, 9'd400, B_ONES);
    check("b_err_wr400", 64'(b_err), 64'd1);
    @(negedge clk);
    check("b_err_pulse", 64'(b_err), 64'd0);
    b_op(1'b0, 9'd144, 40'h0);
    @(negedge clk);
    check("b_rsp_valid_144", 64'(b_rsp_valid), 64'd1);
    check("b_rdata_144", 64'(b_rdata), 64'h12_3456789A);
    b_op(1'b0, 9'd300, 40'h0);
    check("b_err_rd300", 64'(b_err), 64'd1);
    @(negedge clk);
    check("b_rsp_valid_300", 64'(b_rsp_valid), 64'd1);
    check("b_rdata_300", 64'(b_rdata), 64'd0);
    b_op(1'b1, 9'd299, 40'hAB_CDEF0123);
    b_op(1'b0, 9'd299, 40'h0);
    @(negedge clk);
    check("b_rsp_valid_299", 64'(b_rsp_valid), 64'd1);
    check("b_rdata_299", 64'(b_rdata), 64'hAB_CDEF0123);
    @(negedge clk);
    check("b_rsp_pulse", 64'(b_rsp_valid), 64'd0);

    check("a_sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
